// File: rtl/fft_frame_loader.sv
// Collects a serial stream of complex samples into ping-pong frame banks for a parallel-input FFT.
// Latency: frame_valid rises one cycle after the sample that completes a frame.
// Backpressure: in_ready drops while both banks hold unconsumed frames; a presented frame is held until frame_ready.
module fft_frame_loader #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W:0]   in_re,
  input  logic signed [W:0]   in_im,
  input  logic                in_last,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic signed [W:0]   frame_x [N][1:0],
  output logic                frame_err
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Two frame banks; contents are never reset, only overwritten by new samples
  logic signed [W:0] bank [2][N][1:0];

  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] idx;
  logic [1:0]    full_cnt;
  logic [1:0]    full_nxt;

  logic accept;
  logic done;
  logic trunc;
  logic consume;

  // Ready is held low during reset so nothing is accepted while state is being cleared
  assign in_ready = ~rst & (full_cnt < 2'd2);
  assign accept   = in_valid & in_ready;
  assign done     = accept & (idx == LAST_IDX);
  assign trunc    = accept & in_last & (idx != LAST_IDX);
  assign consume  = frame_valid & frame_ready;

  // Net change in stored frames: a simultaneous completion and consumption cancel out
  always_comb begin
    full_nxt = full_cnt + {1'b0, done} - {1'b0, consume};
  end

  // Write the accepted sample into the current slot of the write bank
  always_ff @(posedge clk) begin
    if (accept) begin
      bank[wr_bank][idx][0] <= in_re;
      bank[wr_bank][idx][1] <= in_im;
    end
  end

  // Frame assembly, bank pointers, occupancy and the registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full_cnt    <= 2'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (done) begin
          // A full frame completes even if in_last arrives with it
          idx     <= '0;
          wr_bank <= ~wr_bank;
        end else if (in_last) begin
          // Short frame: restart the slot index and leave the bank to be overwritten
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
      if (consume) begin
        rd_bank <= ~rd_bank;
      end
      full_cnt    <= full_nxt;
      frame_valid <= (full_nxt != 2'd0);
      frame_err   <= trunc;
    end
  end

  // Present the read bank only while a frame is valid, otherwise zeros
  always_comb begin
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < 2; c++) begin
        frame_x[k][c] = '0;
        if (frame_valid) begin
          frame_x[k][c] = bank[rd_bank][k][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader (N=4, W=16).
// Table-driven cycle vectors plus hand-written reset and random streaming sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_fft_frame_loader;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SW = W + 1;
  localparam int NF = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [W:0] in_re;
  logic signed [W:0] in_im;
  logic              in_last;
  logic              frame_valid;
  logic              frame_ready;
  logic signed [W:0] frame_x [N][1:0];
  logic              frame_err;

  int checks = 0;
  int errors = 0;

  fft_frame_loader #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_last    (in_last),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_x    (frame_x),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    vld;
    int    v;
    bit    last;
    bit    rdy;
    bit    ir;
    bit    fv;
    bit    err;
    int    base;
  } vec_t;

  typedef struct {
    logic signed [W:0] re [N];
    logic signed [W:0] im [N];
  } frame_t;

  vec_t   tbl [$];
  frame_t fq  [$];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected frame: sample k carries re = base+k+1, im = -(base+k+1); zeros when no frame is valid
  task automatic chk_frame(input string name, input bit fv, input int base);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s x[%0d].re", name, k), frame_x[k][0], fv ? base + k + 1 : 0);
      chk($sformatf("%s x[%0d].im", name, k), frame_x[k][1], fv ? -(base + k + 1) : 0);
    end
  endtask

  task automatic add(input string tag, input bit vld, input int v, input bit last, input bit rdy,
                     input bit ir, input bit fv, input bit err, input int base);
    vec_t r;
    r.tag = tag; r.vld = vld; r.v = v; r.last = last; r.rdy = rdy;
    r.ir = ir; r.fv = fv; r.err = err; r.base = base;
    tbl.push_back(r);
  endtask

  task automatic cyc(input bit vld, input int v, input bit last, input bit rdy);
    @(negedge clk);
    in_valid    = vld;
    in_re       = SW'(v);
    in_im       = SW'(-v);
    in_last     = last;
    frame_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string name, input bit ir, input bit fv, input bit err);
    chk({name, " in_ready"}, in_ready, ir);
    chk({name, " frame_valid"}, frame_valid, fv);
    chk({name, " frame_err"}, frame_err, err);
  endtask

  initial begin
    frame_t cur;
    frame_t expf;
    int     stalls;
    int     seen;

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0; frame_ready = 1'b0;

    // Reset state
    #3;
    chk_status("reset", 1'b0, 1'b0, 1'b0);
    chk_frame("reset", 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", in_ready, 1);

    // Basic streaming with frame_ready high
    add("stream", 1, 1, 0, 1, 1, 0, 0, 0);
    add("stream", 1, 2, 0, 1, 1, 0, 0, 0);
    add("stream", 1, 3, 0, 1, 1, 0, 0, 0);
    add("stream", 1, 4, 0, 1, 1, 1, 0, 0);
    add("stream", 0, 0, 0, 1, 1, 0, 0, 0);
    // Both banks fill with frame_ready low; 9th sample refused
    for (int v = 11; v <= 13; v++) add("full", 1, v, 0, 0, 1, 0, 0, 0);
    add("full", 1, 14, 0, 0, 1, 1, 0, 10);
    for (int v = 15; v <= 17; v++) add("full", 1, v, 0, 0, 1, 1, 0, 10);
    add("full", 1, 18, 0, 0, 0, 1, 0, 10);
    add("full", 1, 99, 0, 0, 0, 1, 0, 10);
    add("full", 0, 0, 0, 1, 1, 1, 0, 14);
    add("full", 0, 0, 0, 1, 1, 0, 0, 0);
    // Truncated frame followed by a clean one
    add("trunc", 1, 5, 0, 0, 1, 0, 0, 0);
    add("trunc", 1, 6, 1, 0, 1, 0, 1, 0);
    add("trunc", 1, 21, 0, 0, 1, 0, 0, 0);
    add("trunc", 1, 22, 0, 0, 1, 0, 0, 0);
    add("trunc", 1, 23, 0, 0, 1, 0, 0, 0);
    add("trunc", 1, 24, 0, 0, 1, 1, 0, 20);
    // Completion and consumption on the same cycle
    for (int v = 31; v <= 33; v++) add("swap", 1, v, 0, 0, 1, 1, 0, 20);
    add("swap", 1, 34, 0, 1, 1, 1, 0, 30);
    add("swap", 0, 0, 0, 1, 1, 0, 0, 0);
    // in_last on the final slot is an ordinary full frame
    for (int v = 41; v <= 43; v++) add("last4", 1, v, 0, 0, 1, 0, 0, 0);
    add("last4", 1, 44, 1, 0, 1, 1, 0, 40);
    add("last4", 0, 0, 0, 1, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].vld, tbl[i].v, tbl[i].last, tbl[i].rdy);
      chk_status($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].ir, tbl[i].fv, tbl[i].err);
      chk_frame($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].fv, tbl[i].base);
    end

    // Asynchronous reset with one frame pending and another partially loaded
    for (int v = 51; v <= 54; v++) cyc(1, v, 0, 0);
    chk_frame("areset pending", 1'b1, 50);
    for (int v = 55; v <= 57; v++) cyc(1, v, 0, 0);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_status("areset", 1'b0, 1'b0, 1'b0);
    chk_frame("areset", 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("areset release in_ready", in_ready, 1);
    for (int v = 61; v <= 63; v++) begin
      cyc(1, v, 0, 0);
      chk_status($sformatf("after areset v%0d", v), 1'b1, 1'b0, 1'b0);
    end
    cyc(1, 64, 0, 0);
    chk_status("after areset v64", 1'b1, 1'b1, 1'b0);
    chk_frame("after areset", 1'b1, 60);
    cyc(0, 0, 0, 1);
    chk("after areset drain frame_valid", frame_valid, 0);

    // Continuous random stream with frame_ready held high
    stalls = 0;
    seen   = 0;
    for (int c = 0; c < NF * N + 3; c++) begin
      @(negedge clk);
      frame_ready = 1'b1;
      if (c < NF * N) begin
        in_valid = 1'b1;
        in_re    = SW'($urandom);
        in_im    = SW'($urandom);
        in_last  = ((c % N) == N - 1);
        cur.re[c % N] = in_re;
        cur.im[c % N] = in_im;
        if (!in_ready) stalls++;
        if ((c % N) == N - 1) fq.push_back(cur);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(posedge clk);
      #1;
      if (frame_valid) begin
        chk("rand frame expected", fq.size() > 0, 1);
        if (fq.size() > 0) begin
          expf = fq.pop_front();
          for (int k = 0; k < N; k++) begin
            chk($sformatf("rand f%0d x[%0d].re", seen, k), frame_x[k][0], expf.re[k]);
            chk($sformatf("rand f%0d x[%0d].im", seen, k), frame_x[k][1], expf.im[k]);
          end
          seen++;
        end
      end
    end
    chk("rand stall cycles", stalls, 0);
    chk("rand frames seen", seen, NF);
    chk("rand frames left", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter N, default 4: complex points per frame; power of two, at least 2.
REQ-002 SHALL have parameter W, default 16: each real or imaginary sample is a signed W+1-bit value [W:0], matching the FFT input width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream sample is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the loader can accept a sample this cycle.
REQ-007 SHALL have port in_re, input, signed W+1 bits: real part of the sample.
REQ-008 SHALL have port in_im, input, signed W+1 bits: imaginary part of the sample.
REQ-009 SHALL have port in_last, input, 1 bit: the upstream marks this sample as the final one of its frame.
REQ-010 SHALL have port frame_valid, output, 1 bit: a complete frame is presented.
REQ-011 SHALL have port frame_ready, input, 1 bit: the downstream FFT consumes the frame this cycle.
REQ-012 SHALL have port frame_x, output, signed [W:0] x[N][1:0]: the parallel frame, with [k][0] = real and [k][1] = imaginary of sample k, in arrival order.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is truncated.

Function
REQ-014 SHALL hold two frame banks (ping-pong), a write bank pointer wr_bank, a read bank pointer rd_bank, a sample index idx (0..N-1) and a full-bank count full_cnt (0..2).
REQ-015 SHALL drive in_ready = (full_cnt < 2) combinationally; the loader accepts a sample when in_valid and in_ready are both high.
REQ-016 SHALL, on an accepted sample, store {in_re, in_im} into bank[wr_bank][idx].
REQ-017 SHALL, on an accepted sample with idx < N-1 and in_last = 0, increment idx.
REQ-018 SHALL, on an accepted sample with idx = N-1 (regardless of in_last), set idx to 0, toggle wr_bank and increment full_cnt.
REQ-019 SHALL, on an accepted sample with in_last = 1 and idx < N-1, discard the partial frame: set idx to 0, leave wr_bank and full_cnt unchanged, and pulse frame_err high for exactly the next cycle.
REQ-020 SHALL drive frame_valid = (full_cnt > 0), registered, so that frame_valid rises one cycle after the accepted sample that completes the frame.
REQ-021 SHALL drive frame_x from bank[rd_bank] while frame_valid = 1, and drive all zeros while frame_valid = 0.
REQ-022 SHALL hold frame_x and frame_valid stable while frame_valid = 1 and frame_ready = 0.
REQ-023 SHALL, on frame_valid and frame_ready both high, toggle rd_bank and decrement full_cnt.
REQ-024 SHALL leave full_cnt unchanged on a cycle in which a frame completes and a frame is consumed simultaneously, with both pointers toggling.
REQ-025 SHALL ignore frame_ready while frame_valid = 0.
REQ-026 SHALL never overwrite a full bank, since in_ready = 0 when both banks are full.
REQ-027 SHALL sustain one sample per cycle indefinitely when frame_ready is high at least once every N cycles.
REQ-028 SHALL perform no arithmetic on samples: no scaling, no sign change and no reordering.

Reset
REQ-029 SHALL, while rst = 1, force idx = 0, wr_bank = 0, rd_bank = 0, full_cnt = 0, frame_valid = 0, frame_err = 0, in_ready = 0 and frame_x = all zeros.
REQ-030 SHALL drive in_ready = 1 from the first cycle after rst deasserts.
REQ-031 SHALL NOT reset bank contents.
REQ-032 SHALL, if reset is asserted mid-frame or with frames pending, discard all partial and pending frames, with no frame_err pulse.

Verification (N=4, W=16)
REQ-033 SHALL cover: with frame_ready held high, stream re = 1, 2, 3, 4 and im = -1, -2, -3, -4 -> frame_valid high one cycle after the 4th sample, frame_x[0] = {1,-1} through frame_x[3] = {4,-4}.
REQ-034 SHALL cover: with frame_ready held low, stream 8 samples back-to-back -> two frames stored and in_ready = 0 after the 8th sample; the 9th sample is not accepted; one frame_ready pulse -> the second frame is presented and in_ready returns to 1.
REQ-035 SHALL cover: in_last asserted on the 2nd sample -> frame_err pulses for one cycle and frame_valid stays 0; the next 4 samples form a clean frame.
REQ-036 SHALL cover: frame_ready asserted on the same cycle the next frame's 4th sample is accepted -> full_cnt stays 1, frame_valid stays high, and frame_x switches to the new frame.
REQ-037 SHALL cover: rst asserted asynchronously after 3 samples -> frame_valid = 0 and in_ready = 0 immediately; after release, 4 new samples produce a frame containing only the new data.
REQ-038 SHALL cover: a continuous random stream with frame_ready high -> zero stall cycles, and every frame matches the reference model in order.
